// File: rtl/imm_gen_pkg.sv
// Shared types and RV32I/RV64I opcode constants for the immediate-generation stage.
package imm_gen_pkg;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5
  } fmt_t;

  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_IMM32 = 7'b0011011;
  localparam logic [6:0] LOAD     = 7'b0000011;
  localparam logic [6:0] JALR     = 7'b1100111;
  localparam logic [6:0] STORE    = 7'b0100011;
  localparam logic [6:0] BRANCH   = 7'b1100011;
  localparam logic [6:0] LUI      = 7'b0110111;
  localparam logic [6:0] AUIPC    = 7'b0010111;
  localparam logic [6:0] JAL      = 7'b1101111;
  localparam logic [6:0] OP       = 7'b0110011;
  localparam logic [6:0] OP32     = 7'b0111011;

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate extraction: sign-extended imm, format, illegal flag and
// whether the instruction needs a PC-relative target.
module imm_decode
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output fmt_t            fmt,
  output logic            illegal,
  output logic            pc_rel
);

  // Every listed opcode ends in 2'b11, so compressed-space words fall to default.
  always_comb begin
    imm     = '0;
    fmt     = FMT_NONE;
    illegal = 1'b1;
    pc_rel  = 1'b0;
    case (instr[6:0])
      OP_IMM, LOAD, JALR: begin
        imm     = XLEN'($signed(instr[31:20]));
        fmt     = FMT_I;
        illegal = 1'b0;
      end
      OP_IMM32: begin
        if (XLEN == 64) begin
          imm     = XLEN'($signed(instr[31:20]));
          fmt     = FMT_I;
          illegal = 1'b0;
        end
      end
      STORE: begin
        imm     = XLEN'($signed({instr[31:25], instr[11:7]}));
        fmt     = FMT_S;
        illegal = 1'b0;
      end
      BRANCH: begin
        imm     = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
        fmt     = FMT_B;
        illegal = 1'b0;
        pc_rel  = 1'b1;
      end
      LUI, AUIPC: begin
        imm     = XLEN'($signed({instr[31:12], 12'b0}));
        fmt     = FMT_U;
        illegal = 1'b0;
        pc_rel  = (instr[6:0] == AUIPC);
      end
      JAL: begin
        imm     = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
        fmt     = FMT_J;
        illegal = 1'b0;
        pc_rel  = 1'b1;
      end
      OP: illegal = 1'b0;
      OP32: begin
        if (XLEN == 64) illegal = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate-generation stage: decode + PC-relative adder feeding a
// DEPTH-entry circular output buffer with valid/ready on both sides.
module imm_gen_stage
  import imm_gen_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int DEPTH = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     in_instr_i,
  input  logic [XLEN-1:0] in_pc_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] out_immed_o,
  output logic [2:0]      out_fmt_o,
  output logic [XLEN-1:0] out_target_o,
  output logic            out_illegal_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [XLEN-1:0] imm;
    fmt_t            fmt;
    logic [XLEN-1:0] target;
    logic            illegal;
  } entry_t;

  logic [XLEN-1:0] dec_imm;
  fmt_t            dec_fmt;
  logic            dec_illegal;
  logic            dec_pc_rel;
  entry_t          wr_entry;
  entry_t          head;

  entry_t          mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             push, pop;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .instr   (in_instr_i),
    .imm     (dec_imm),
    .fmt     (dec_fmt),
    .illegal (dec_illegal),
    .pc_rel  (dec_pc_rel)
  );

  always_comb begin
    wr_entry.imm     = dec_imm;
    wr_entry.fmt     = dec_fmt;
    wr_entry.target  = dec_pc_rel ? (in_pc_i + dec_imm) : '0;
    wr_entry.illegal = dec_illegal;
  end

  assign in_ready_o  = (count_reg != CNT_W'(DEPTH));
  assign out_valid_o = (count_reg != '0);
  assign push        = in_valid_i & in_ready_o;
  assign pop         = out_valid_o & out_ready_i;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (push) wr_ptr_next = (wr_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_reg + PTR_W'(1);
    if (pop)  rd_ptr_next = (rd_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_reg + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  // Flush wins over any handshake in the same cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Storage needs no reset: empty slots are masked at the output.
  always_ff @(posedge clk_i) begin
    if (push && !flush_i) mem[wr_ptr_reg] <= wr_entry;
  end

  assign head          = mem[rd_ptr_reg];
  assign out_immed_o   = out_valid_o ? head.imm     : '0;
  assign out_fmt_o     = out_valid_o ? head.fmt     : 3'd0;
  assign out_target_o  = out_valid_o ? head.target  : '0;
  assign out_illegal_o = out_valid_o ? head.illegal : 1'b0;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Directed bench for imm_gen_stage (XLEN=64, DEPTH=2) with an expected-result queue.
module tb_imm_gen_stage;

  localparam int XLEN  = 64;
  localparam int DEPTH = 2;

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic [63:0] target;
    logic        illegal;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        flush_i = 1'b0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [31:0] in_instr_i = '0;
  logic [63:0] in_pc_i = '0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [63:0] out_immed_o;
  logic [2:0]  out_fmt_o;
  logic [63:0] out_target_o;
  logic        out_illegal_o;

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];
  logic acc;

  always #5 clk_i = ~clk_i;

  imm_gen_stage #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .flush_i       (flush_i),
    .in_valid_i    (in_valid_i),
    .in_ready_o    (in_ready_o),
    .in_instr_i    (in_instr_i),
    .in_pc_i       (in_pc_i),
    .out_valid_o   (out_valid_o),
    .out_ready_i   (out_ready_i),
    .out_immed_o   (out_immed_o),
    .out_fmt_o     (out_fmt_o),
    .out_target_o  (out_target_o),
    .out_illegal_o (out_illegal_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".valid"},   64'(out_valid_o),   64'd0);
    chk({tag, ".ready"},   64'(in_ready_o),    64'd1);
    chk({tag, ".imm"},     out_immed_o,        64'd0);
    chk({tag, ".fmt"},     64'(out_fmt_o),     64'd0);
    chk({tag, ".target"},  out_target_o,       64'd0);
    chk({tag, ".illegal"}, 64'(out_illegal_o), 64'd0);
  endtask

  // One clock cycle: drive inputs, check head against the queue, model push/pop.
  task automatic cycle(input logic v, input logic [31:0] instr, input logic [63:0] pc,
                       input exp_t e, input logic rdy, input logic fl, output logic accepted);
    exp_t h;
    in_valid_i  = v;
    in_instr_i  = instr;
    in_pc_i     = pc;
    out_ready_i = rdy;
    flush_i     = fl;
    #1;
    chk("out_valid", 64'(out_valid_o), 64'(exp_q.size() != 0));
    chk("in_ready",  64'(in_ready_o),  64'(exp_q.size() != DEPTH));
    if (exp_q.size() != 0) begin
      h = exp_q[0];
      chk("imm",     out_immed_o,        h.imm);
      chk("fmt",     64'(out_fmt_o),     64'(h.fmt));
      chk("target",  out_target_o,       h.target);
      chk("illegal", 64'(out_illegal_o), 64'(h.illegal));
    end else begin
      chk("empty.imm", out_immed_o, 64'd0);
      chk("empty.fmt", 64'(out_fmt_o), 64'd0);
    end
    accepted = v && (exp_q.size() != DEPTH) && !fl;
    $display("t=%0t v=%0b instr=%h pc=%h rdy=%0b flush=%0b accepted=%0b out_valid=%0b imm=%h fmt=%0d tgt=%h ill=%0b",
             $time, v, instr, pc, rdy, fl, accepted, out_valid_o, out_immed_o, out_fmt_o,
             out_target_o, out_illegal_o);
    if (fl) exp_q.delete();
    else begin
      if (rdy && exp_q.size() != 0) void'(exp_q.pop_front());
      if (accepted) exp_q.push_back(e);
    end
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  function automatic exp_t mk(input logic [63:0] imm, input logic [2:0] fmt,
                              input logic [63:0] tgt, input logic ill);
    exp_t e;
    e.imm = imm; e.fmt = fmt; e.target = tgt; e.illegal = ill;
    return e;
  endfunction

  initial begin
    exp_t none;
    none = mk(64'd0, 3'd0, 64'd0, 1'b0);

    // Reset state
    #2;
    chk_idle("reset");
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk_idle("post_reset");

    // Streaming decode, one per cycle with consumer ready
    cycle(1, 32'hFFF00093, 64'h100,  mk(64'hFFFFFFFFFFFFFFFF, 3'd1, 64'd0, 1'b0), 1, 0, acc);
    cycle(1, 32'hFE512E23, 64'h104,  mk(64'hFFFFFFFFFFFFFFFC, 3'd2, 64'd0, 1'b0), 1, 0, acc);
    cycle(1, 32'h800000B7, 64'h108,  mk(64'hFFFFFFFF80000000, 3'd4, 64'd0, 1'b0), 1, 0, acc);
    cycle(1, 32'hFE000CE3, 64'h1000, mk(64'hFFFFFFFFFFFFFFF8, 3'd3, 64'h0FF8, 1'b0), 1, 0, acc);
    cycle(1, 32'h0010006F, 64'h0,    mk(64'h800, 3'd5, 64'h800, 1'b0), 1, 0, acc);
    cycle(1, 32'h00000000, 64'h20,   mk(64'd0, 3'd0, 64'd0, 1'b1), 1, 0, acc);
    cycle(1, 32'h0000007F, 64'h24,   mk(64'd0, 3'd0, 64'd0, 1'b1), 1, 0, acc);
    cycle(1, 32'h00B50533, 64'h28,   mk(64'd0, 3'd0, 64'd0, 1'b0), 1, 0, acc);
    cycle(1, 32'h00001297, 64'h2000, mk(64'h1000, 3'd4, 64'h3000, 1'b0), 1, 0, acc);
    cycle(1, 32'hFFFFF297, 64'h800,  mk(64'hFFFFFFFFFFFFF000, 3'd4, 64'hFFFFFFFFFFFFF800, 1'b0), 1, 0, acc);
    cycle(1, 32'h0010809B, 64'h30,   mk(64'h1, 3'd1, 64'd0, 1'b0), 1, 0, acc);
    cycle(0, 32'h0, 64'h0, none, 1, 0, acc);
    chk("drained", 64'(exp_q.size()), 64'd0);

    // Backpressure: three offers with consumer stalled
    cycle(1, 32'h00100093, 64'h0, mk(64'h1, 3'd1, 64'd0, 1'b0), 0, 0, acc);
    chk("bp.acc1", 64'(acc), 64'd1);
    cycle(1, 32'h00200093, 64'h0, mk(64'h2, 3'd1, 64'd0, 1'b0), 0, 0, acc);
    chk("bp.acc2", 64'(acc), 64'd1);
    cycle(1, 32'h00300093, 64'h0, mk(64'h3, 3'd1, 64'd0, 1'b0), 0, 0, acc);
    chk("bp.full_reject", 64'(acc), 64'd0);
    cycle(1, 32'h00300093, 64'h0, mk(64'h3, 3'd1, 64'd0, 1'b0), 0, 0, acc);
    chk("bp.head_held", 64'(acc), 64'd0);
    cycle(1, 32'h00300093, 64'h0, mk(64'h3, 3'd1, 64'd0, 1'b0), 1, 0, acc);
    chk("bp.no_passthru", 64'(acc), 64'd0);
    cycle(1, 32'h00300093, 64'h0, mk(64'h3, 3'd1, 64'd0, 1'b0), 1, 0, acc);
    chk("bp.acc3", 64'(acc), 64'd1);
    cycle(0, 32'h0, 64'h0, none, 1, 0, acc);
    cycle(0, 32'h0, 64'h0, none, 1, 0, acc);
    chk("bp.drained", 64'(exp_q.size()), 64'd0);

    // Flush with a push in the same cycle
    cycle(1, 32'h00400093, 64'h0, mk(64'h4, 3'd1, 64'd0, 1'b0), 0, 0, acc);
    cycle(1, 32'h00500093, 64'h0, mk(64'h5, 3'd1, 64'd0, 1'b0), 0, 0, acc);
    cycle(1, 32'h00600093, 64'h0, mk(64'h6, 3'd1, 64'd0, 1'b0), 1, 1, acc);
    chk_idle("flush");
    cycle(0, 32'h0, 64'h0, none, 1, 0, acc);

    // Asynchronous reset mid-stream
    cycle(1, 32'h00700093, 64'h0, mk(64'h7, 3'd1, 64'd0, 1'b0), 0, 0, acc);
    cycle(1, 32'h00800093, 64'h0, mk(64'h8, 3'd1, 64'd0, 1'b0), 0, 0, acc);
    in_valid_i = 1'b0;
    #2;
    rst_ni = 1'b0;
    #1;
    chk_idle("async_reset");
    exp_q.delete();
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk_idle("after_reset");
    cycle(1, 32'hFFF00093, 64'h0, mk(64'hFFFFFFFFFFFFFFFF, 3'd1, 64'd0, 1'b0), 1, 0, acc);
    cycle(0, 32'h0, 64'h0, none, 1, 0, acc);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
